rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register-file data width.
REQ-002 SHALL have parameter REG_AW, default 4, register address width (16 registers).
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, consecutive lost grants before the LU queue is forced onto the port.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports wb_write in 1, wb_reg in REG_AW, wb_data in DATA_W: write-back stage write request, destination and data.
REQ-007 SHALL have ports lu_valid in 1, lu_reg in REG_AW, lu_data in DATA_W: long-latency-unit result offer.
REQ-008 SHALL have port lu_ready  out  1  queue can accept an LU result this cycle.
REQ-009 SHALL have port wb_stall  out  1  WB request not granted; the WB stage holds its inputs.
REQ-010 SHALL have ports rf_write out 1, rf_write_reg out REG_AW, rf_write_data out DATA_W: the single register-file write port.
REQ-011 SHALL have port pending_mask  out  2**REG_AW  one bit per register with a queued, unwritten LU result.

Function
REQ-012 SHALL hold LU results in a 2-entry in-order FIFO; an LU result is transferred when lu_valid && lu_ready at the rising edge.
REQ-013 SHALL drive lu_ready = (FIFO count < 2), from registered state only, with no same-cycle pass-through when full.
REQ-014 SHALL grant the FIFO head (LU grant) when the FIFO is non-empty and any of these holds: wb_write=0; starve count = STARVE_LIMIT; wb_reg matches the reg of any valid FIFO entry (WAW ordering).
REQ-015 SHALL otherwise grant WB when wb_write=1; otherwise, with the FIFO empty, the port is idle.
REQ-016 On WB grant, SHALL drive rf_write=1, rf_write_reg=wb_reg, rf_write_data=wb_data combinationally, with zero latency.
REQ-017 On LU grant, SHALL drive the port from the FIFO head, pop it at the clock edge, and set wb_stall=wb_write.
REQ-018 When idle, SHALL drive rf_write=0 and rf_write_reg, rf_write_data = 0.
REQ-019 SHALL keep a starve counter (width clog2(STARVE_LIMIT+1)), incremented each cycle the FIFO is non-empty and WB is granted, and cleared on LU grant or when the FIFO is empty.
REQ-020 The minimum LU latency (lu_valid accepted to rf_write) SHALL be 1 cycle.
REQ-021 Simultaneous push and pop SHALL be legal at count 1 (count stays 1) and at count 2 (not possible, because lu_ready=0).
REQ-022 pending_mask SHALL be the OR of one-hot(reg) over valid FIFO entries, registered-state based; two entries to the same register set one bit.
REQ-023 FIFO pointers SHALL wrap modulo 2; the count SHALL never exceed 2 or underflow.

Reset
REQ-024 While rst=1: FIFO empty, starve count 0, rf_write=0, rf_write_reg=0, rf_write_data=0, wb_stall=0, lu_ready=0, pending_mask=0.
REQ-025 Reset asserted mid-operation SHALL discard queued LU results with no RF write; lu_ready=1 in the first cycle after deassertion.

Structure
REQ-026 DATA_W and REG_AW defaults and the STARVE_LIMIT constant SHALL live in the shared CPU package.
REQ-027 The FIFO SHALL be a sub-module, lu_result_fifo (depth 2, payload REG_AW+DATA_W, push/pop/count/entry-valid outputs); arbitration stays in rf_write_arbiter.

Verification
REQ-028 WB only: wb_write=1, wb_reg=5, wb_data=0x1234, FIFO empty -> same cycle rf_write=1, reg 5, data 0x1234, wb_stall=0.
REQ-029 LU only: lu_valid=1, lu_reg=3, lu_data=0xBEEF at cycle N -> rf_write=1, reg 3, data 0xBEEF at cycle N+1; pending_mask bit 3 is high in cycle N+1 only.
REQ-030 Starvation: queue lu_reg=2, then wb_write=1 to reg 7 continuously -> WB granted 3 cycles, 4th cycle LU grant with wb_stall=1, then WB resumes.
REQ-031 WAW: FIFO holds reg 9 = 0x0001, wb_write to reg 9 = 0x0002 -> LU write 0x0001 first with wb_stall=1, next cycle WB write 0x0002.
REQ-032 Full: two LU pushes while WB is busy -> lu_ready=0; an lu_valid offer is held until a pop, after which lu_ready=1 the next cycle; no result is lost or duplicated.
REQ-033 Reset mid-queue: 2 entries queued, assert rst asynchronously -> rf_write=0 immediately, pending_mask=0, no queued write appears after release.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared CPU constants and types for the register-file write-port arbiter.
package rf_write_arbiter_pkg;

   // Core datapath defaults shared across the CPU.
   localparam int CPU_DATA_W       = 16;
   localparam int CPU_REG_AW       = 4;
   localparam int CPU_STARVE_LIMIT = 3;

   // Depth of the long-latency-unit result queue.
   localparam int LU_FIFO_DEPTH    = 2;

   // Owner of the register-file write port in the current cycle.
   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_WB   = 2'd1,
      GNT_LU   = 2'd2
   } rf_grant_e;

endpackage : rf_write_arbiter_pkg

// File: rtl/rf_write_arbiter_fifo.sv
// Two-entry in-order queue of long-latency-unit results (destination + data).
// Exposes per-slot valid/register so the arbiter can detect WAW hazards and
// build the pending-register mask without reaching into the storage.
module lu_result_fifo
   import rf_write_arbiter_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int REG_AW = CPU_REG_AW
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic [REG_AW-1:0]               push_reg,
   input  logic [DATA_W-1:0]               push_data,
   input  logic                            pop,
   output logic [REG_AW-1:0]               head_reg,
   output logic [DATA_W-1:0]               head_data,
   output logic [1:0]                      count,
   output logic [LU_FIFO_DEPTH-1:0]        entry_valid,
   output logic [LU_FIFO_DEPTH-1:0][REG_AW-1:0] entry_reg
);

   logic [REG_AW-1:0] reg_mem_q  [LU_FIFO_DEPTH];
   logic [DATA_W-1:0] data_mem_q [LU_FIFO_DEPTH];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q,  count_d;
   logic              push_ok;
   logic              pop_ok;

   // Full/empty guards keep the count inside 0..2 whatever the caller does.
   assign push_ok = push && (count_q != 2'd2);
   assign pop_ok  = pop  && (count_q != 2'd0);

   // Next pointer/count; pointers wrap naturally in one bit.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Queue control state; reset discards anything queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: slots are only read while marked valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         reg_mem_q[wr_ptr_q]  <= push_reg;
         data_mem_q[wr_ptr_q] <= push_data;
      end
   end

   generate
      for (genvar gi = 0; gi < LU_FIFO_DEPTH; gi++) begin : g_slot
         // A slot is live when the queue is full, or it is the sole head.
         assign entry_valid[gi] = (count_q == 2'd2) ||
                                  ((count_q == 2'd1) && (rd_ptr_q == gi[0]));
         assign entry_reg[gi]   = reg_mem_q[gi];
      end
   endgenerate

   assign head_reg  = reg_mem_q[rd_ptr_q];
   assign head_data = data_mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule : lu_result_fifo

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the write-back
// stage (zero-latency, combinational grant) and queued long-latency-unit
// results. LU wins when WB is idle, when WB would overtake a queued write to
// the same register, or when the queue has lost too many consecutive grants.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int DATA_W       = CPU_DATA_W,
   parameter int REG_AW       = CPU_REG_AW,
   parameter int STARVE_LIMIT = CPU_STARVE_LIMIT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wb_write,
   input  logic [REG_AW-1:0]       wb_reg,
   input  logic [DATA_W-1:0]       wb_data,
   input  logic                    lu_valid,
   input  logic [REG_AW-1:0]       lu_reg,
   input  logic [DATA_W-1:0]       lu_data,
   output logic                    lu_ready,
   output logic                    wb_stall,
   output logic                    rf_write,
   output logic [REG_AW-1:0]       rf_write_reg,
   output logic [DATA_W-1:0]       rf_write_data,
   output logic [(1<<REG_AW)-1:0]  pending_mask
);

   localparam int NREGS    = 1 << REG_AW;
   localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [NREGS-1:0]    ONE_HOT_LSB = NREGS'(1);
   localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);

   logic [REG_AW-1:0]                      head_reg;
   logic [DATA_W-1:0]                      head_data;
   logic [1:0]                             fifo_count;
   logic [LU_FIFO_DEPTH-1:0]               entry_valid;
   logic [LU_FIFO_DEPTH-1:0][REG_AW-1:0]   entry_reg;
   logic [LU_FIFO_DEPTH-1:0]               waw_hit;
   logic [LU_FIFO_DEPTH-1:0][NREGS-1:0]    slot_mask;
   logic                                   fifo_empty;
   logic                                   push;
   logic                                   pop;
   rf_grant_e                              grant;
   logic [STARVE_W-1:0]                    starve_q, starve_d;

   // Ready is a function of the registered count only, forced low in reset.
   assign lu_ready   = ~rst && (fifo_count != 2'd2);
   assign push       = lu_valid && lu_ready;
   assign pop        = (grant == GNT_LU);
   assign fifo_empty = (fifo_count == 2'd0);

   lu_result_fifo #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_reg    (lu_reg),
      .push_data   (lu_data),
      .pop         (pop),
      .head_reg    (head_reg),
      .head_data   (head_data),
      .count       (fifo_count),
      .entry_valid (entry_valid),
      .entry_reg   (entry_reg)
   );

   generate
      for (genvar gi = 0; gi < LU_FIFO_DEPTH; gi++) begin : g_hazard
         // WB must not overtake a queued result for the same register.
         assign waw_hit[gi]   = entry_valid[gi] && (entry_reg[gi] == wb_reg);
         assign slot_mask[gi] = entry_valid[gi] ? (ONE_HOT_LSB << entry_reg[gi])
                                                : '0;
      end
   endgenerate

   // Pending mask: OR of one-hot destinations of all live queue slots.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < LU_FIFO_DEPTH; i++) begin
         pending_mask = pending_mask | slot_mask[i];
      end
   end

   // Grant decision: LU on idle WB, WAW hazard or starvation; else WB.
   always_comb begin
      grant = GNT_IDLE;
      if (!rst) begin
         if (!fifo_empty && (!wb_write || (starve_q == STARVE_MAX) || (|waw_hit))) begin
            grant = GNT_LU;
         end else if (wb_write) begin
            grant = GNT_WB;
         end
      end
   end

   // Drive the write port and the WB stall from the grant.
   always_comb begin
      rf_write      = 1'b0;
      rf_write_reg  = '0;
      rf_write_data = '0;
      wb_stall      = 1'b0;
      case (grant)
         GNT_WB: begin
            rf_write      = 1'b1;
            rf_write_reg  = wb_reg;
            rf_write_data = wb_data;
         end
         GNT_LU: begin
            rf_write      = 1'b1;
            rf_write_reg  = head_reg;
            rf_write_data = head_data;
            wb_stall      = wb_write;
         end
         default: ;
      endcase
   end

   // Starvation count: grows while the queue waits behind WB, else clears.
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || (grant == GNT_LU)) begin
         starve_d = '0;
      end else if ((grant == GNT_WB) && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: each step drives inputs just after the
// falling edge and checks the settled outputs before the next rising edge.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_write;
   logic [3:0]  wb_reg;
   logic [15:0] wb_data;
   logic        lu_valid;
   logic [3:0]  lu_reg;
   logic [15:0] lu_data;
   logic        lu_ready;
   logic        wb_stall;
   logic        rf_write;
   logic [3:0]  rf_write_reg;
   logic [15:0] rf_write_data;
   logic [15:0] pending_mask;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rf_write_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .wb_write      (wb_write),
      .wb_reg        (wb_reg),
      .wb_data       (wb_data),
      .lu_valid      (lu_valid),
      .lu_reg        (lu_reg),
      .lu_data       (lu_data),
      .lu_ready      (lu_ready),
      .wb_stall      (wb_stall),
      .rf_write      (rf_write),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .pending_mask  (pending_mask)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check the whole write port in one go.
   task automatic check_port(input string tag, input logic we, input logic [3:0] r,
                             input logic [15:0] d, input logic st);
      check({tag, ".rf_write"}, {31'd0, rf_write}, {31'd0, we});
      check({tag, ".rf_write_reg"}, {28'd0, rf_write_reg}, {28'd0, r});
      check({tag, ".rf_write_data"}, {16'd0, rf_write_data}, {16'd0, d});
      check({tag, ".wb_stall"}, {31'd0, wb_stall}, {31'd0, st});
      $display("step %s: rf_write=%0b reg=%0d data=%h wb_stall=%0b lu_ready=%0b pending=%h",
               tag, rf_write, rf_write_reg, rf_write_data, wb_stall, lu_ready, pending_mask);
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // Reset with busy inputs: everything must stay quiet.
      rst = 1'b1; wb_write = 1'b1; wb_reg = 4'd5; wb_data = 16'h1234;
      lu_valid = 1'b1; lu_reg = 4'd3; lu_data = 16'h0001;
      #3;
      check_port("reset", 1'b0, 4'd0, 16'h0, 1'b0);
      check("reset.lu_ready", {31'd0, lu_ready}, 32'd0);
      check("reset.pending", {16'd0, pending_mask}, 32'd0);
      next_cycle(); next_cycle();
      rst = 1'b0; wb_write = 1'b0; lu_valid = 1'b0;
      settle();
      check_port("post_reset", 1'b0, 4'd0, 16'h0, 1'b0);
      check("post_reset.lu_ready", {31'd0, lu_ready}, 32'd1);
      check("post_reset.pending", {16'd0, pending_mask}, 32'd0);

      // WB only, same-cycle write.
      next_cycle();
      wb_write = 1'b1; wb_reg = 4'd5; wb_data = 16'h1234;
      settle();
      check_port("wb_only", 1'b1, 4'd5, 16'h1234, 1'b0);

      // LU only, one-cycle latency and a one-cycle pending bit.
      next_cycle();
      wb_write = 1'b0; lu_valid = 1'b1; lu_reg = 4'd3; lu_data = 16'hBEEF;
      settle();
      check_port("lu_offer", 1'b0, 4'd0, 16'h0, 1'b0);
      check("lu_offer.pending", {16'd0, pending_mask}, 32'd0);
      next_cycle();
      lu_valid = 1'b0;
      settle();
      check_port("lu_write", 1'b1, 4'd3, 16'hBEEF, 1'b0);
      check("lu_write.pending", {16'd0, pending_mask}, 32'h0008);
      next_cycle();
      settle();
      check_port("lu_done", 1'b0, 4'd0, 16'h0, 1'b0);
      check("lu_done.pending", {16'd0, pending_mask}, 32'd0);

      // Starvation: three WB grants then a forced LU grant.
      next_cycle();
      lu_valid = 1'b1; lu_reg = 4'd2; lu_data = 16'hAAAA;
      settle();
      check_port("starve_push", 1'b0, 4'd0, 16'h0, 1'b0);
      next_cycle();
      lu_valid = 1'b0; wb_write = 1'b1; wb_reg = 4'd7; wb_data = 16'h0707;
      settle();
      check_port("starve_wb1", 1'b1, 4'd7, 16'h0707, 1'b0);
      check("starve_wb1.pending", {16'd0, pending_mask}, 32'h0004);
      next_cycle(); settle();
      check_port("starve_wb2", 1'b1, 4'd7, 16'h0707, 1'b0);
      next_cycle(); settle();
      check_port("starve_wb3", 1'b1, 4'd7, 16'h0707, 1'b0);
      next_cycle(); settle();
      check_port("starve_lu", 1'b1, 4'd2, 16'hAAAA, 1'b1);
      next_cycle(); settle();
      check_port("starve_wb_resume", 1'b1, 4'd7, 16'h0707, 1'b0);
      check("starve_wb_resume.pending", {16'd0, pending_mask}, 32'd0);

      // WAW: queued reg 9 must be written before WB's reg 9.
      next_cycle();
      wb_write = 1'b0; lu_valid = 1'b1; lu_reg = 4'd9; lu_data = 16'h0001;
      settle();
      check_port("waw_push", 1'b0, 4'd0, 16'h0, 1'b0);
      next_cycle();
      lu_valid = 1'b0; wb_write = 1'b1; wb_reg = 4'd9; wb_data = 16'h0002;
      settle();
      check_port("waw_lu_first", 1'b1, 4'd9, 16'h0001, 1'b1);
      next_cycle(); settle();
      check_port("waw_wb_second", 1'b1, 4'd9, 16'h0002, 1'b0);

      // Full queue: offer is held while lu_ready is low, nothing lost.
      next_cycle();
      wb_reg = 4'd7; wb_data = 16'h7777;
      lu_valid = 1'b1; lu_reg = 4'd1; lu_data = 16'h1111;
      settle();
      check_port("full_a", 1'b1, 4'd7, 16'h7777, 1'b0);
      check("full_a.lu_ready", {31'd0, lu_ready}, 32'd1);
      next_cycle();
      lu_reg = 4'd2; lu_data = 16'h2222;
      settle();
      check_port("full_b", 1'b1, 4'd7, 16'h7777, 1'b0);
      check("full_b.pending", {16'd0, pending_mask}, 32'h0002);
      next_cycle();
      lu_reg = 4'd4; lu_data = 16'h4444;
      settle();
      check("full_c.lu_ready", {31'd0, lu_ready}, 32'd0);
      check("full_c.pending", {16'd0, pending_mask}, 32'h0006);
      check_port("full_c", 1'b1, 4'd7, 16'h7777, 1'b0);
      next_cycle(); settle();
      check("full_d.lu_ready", {31'd0, lu_ready}, 32'd0);
      check_port("full_d", 1'b1, 4'd7, 16'h7777, 1'b0);
      next_cycle(); settle();
      check("full_e.lu_ready", {31'd0, lu_ready}, 32'd0);
      check_port("full_e", 1'b1, 4'd1, 16'h1111, 1'b1);
      next_cycle(); settle();
      check("full_f.lu_ready", {31'd0, lu_ready}, 32'd1);
      check_port("full_f", 1'b1, 4'd7, 16'h7777, 1'b0);
      next_cycle();
      lu_valid = 1'b0; wb_write = 1'b0;
      settle();
      check("full_g.pending", {16'd0, pending_mask}, 32'h0014);
      check_port("full_g", 1'b1, 4'd2, 16'h2222, 1'b0);
      next_cycle(); settle();
      check("full_h.pending", {16'd0, pending_mask}, 32'h0010);
      check_port("full_h", 1'b1, 4'd4, 16'h4444, 1'b0);
      next_cycle(); settle();
      check_port("full_drained", 1'b0, 4'd0, 16'h0, 1'b0);
      check("full_drained.pending", {16'd0, pending_mask}, 32'd0);

      // Reset mid-queue: queued entries vanish without a write.
      next_cycle();
      wb_write = 1'b1; wb_reg = 4'd7; wb_data = 16'h7777;
      lu_valid = 1'b1; lu_reg = 4'd1; lu_data = 16'h0101;
      settle();
      next_cycle();
      lu_reg = 4'd2; lu_data = 16'h0202;
      settle();
      next_cycle();
      lu_valid = 1'b0;
      settle();
      check("rstq.pending_before", {16'd0, pending_mask}, 32'h0006);
      check("rstq.lu_ready_before", {31'd0, lu_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check_port("rstq_async", 1'b0, 4'd0, 16'h0, 1'b0);
      check("rstq_async.pending", {16'd0, pending_mask}, 32'd0);
      check("rstq_async.lu_ready", {31'd0, lu_ready}, 32'd0);
      next_cycle();
      rst = 1'b0; wb_write = 1'b0;
      settle();
      check("rstq_release.lu_ready", {31'd0, lu_ready}, 32'd1);
      check_port("rstq_release", 1'b0, 4'd0, 16'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         next_cycle(); settle();
         check_port("rstq_quiet", 1'b0, 4'd0, 16'h0, 1'b0);
         check("rstq_quiet.pending", {16'd0, pending_mask}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard time bound so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish by 100000");
      $fatal(1, "timeout");
   end

endmodule : tb_rf_write_arbiter
